// File: rtl/output_iop.sv
// Memory-to-device IOP channel: reads the IOCD at X'20'/X'21', streams the
// addressed bytes out on a ready/valid port, then posts status to X'21'.
module output_iop #(
    parameter logic [7:0]  ORDER_WRITE = 8'h05,
    parameter logic [31:0] STATUS_OK   = 32'h0E000000,
    parameter logic [31:0] STATUS_ERR  = 32'h0E800000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         active,
    output logic [15:31] memory_address,
    input  logic [0:31]  memory_data_in,
    output logic [0:31]  memory_data_out,
    output logic [0:3]   wr_enables,
    input  logic [0:2]   iop_func,
    input  logic [21:31] iop_device,
    output logic [0:1]   iop_cc,
    output logic [0:7]   out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_LOAD,
        S_SEND,
        S_STATUS,
        S_DONE
    } state_t;

    localparam logic [0:2]   FUNC_SIO  = 3'd0;
    localparam logic [15:31] ADDR_IOCD = 17'h00020;
    localparam logic [15:31] ADDR_STAT = 17'h00021;

    state_t        state;
    state_t        state_nxt;
    logic [15:33]  p;
    logic [0:15]   count;
    logic [0:7]    order;
    logic [0:31]   data_buf;
    logic [0:1]    cc;

    logic [15:31]  addr_int;
    logic [0:31]   wdata_int;
    logic [0:3]    wen_int;
    logic [0:7]    byte_sel;
    logic          sending;
    logic          handshake;

    // The device number only identifies the channel to the operator.
    logic          unused_device;
    assign unused_device = ^iop_device;

    assign sending   = (state == S_SEND) && active;
    assign handshake = sending && out_ready;

    always_comb begin
        case (p[32:33])
            2'd0:    byte_sel = data_buf[0:7];
            2'd1:    byte_sel = data_buf[8:15];
            2'd2:    byte_sel = data_buf[16:23];
            default: byte_sel = data_buf[24:31];
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_int  = p[15:31];
        wdata_int = '0;
        wen_int   = '0;
        case (state)
            S_IDLE: begin
                if (iop_func == FUNC_SIO) state_nxt = S_FETCH0;
                else                      state_nxt = S_DONE;
            end
            S_FETCH0: begin
                addr_int  = ADDR_IOCD;
                state_nxt = S_FETCH1;
            end
            S_FETCH1: begin
                addr_int = ADDR_STAT;
                if (order != ORDER_WRITE)             state_nxt = S_STATUS;
                else if (memory_data_in[16:31] == '0) state_nxt = S_STATUS;
                else                                  state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (handshake) begin
                    if (count == 16'd1)        state_nxt = S_STATUS;
                    else if (p[32:33] == 2'd3) state_nxt = S_LOAD;
                end
            end
            S_STATUS: begin
                addr_int  = ADDR_STAT;
                // Only an illegal order reaches STATUS with order != write.
                wdata_int = (order == ORDER_WRITE) ? STATUS_OK : STATUS_ERR;
                wen_int   = 4'hF;
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_DONE;
            end
        endcase
        if (!active) state_nxt = S_IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p        <= '0;
            count    <= '0;
            order    <= '0;
            data_buf <= '0;
            cc       <= '0;
        end else if (active) begin
            case (state)
                S_IDLE: begin
                    cc <= 2'b00;
                end
                S_FETCH0: begin
                    order <= memory_data_in[0:7];
                    p     <= memory_data_in[13:31];
                end
                S_FETCH1: begin
                    count <= memory_data_in[16:31];
                    if (order != ORDER_WRITE) cc <= 2'b10;
                end
                S_LOAD: begin
                    data_buf <= memory_data_in;
                end
                S_SEND: begin
                    if (handshake) begin
                        p     <= p + 19'd1;
                        count <= count - 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = sending;
    assign out_data  = (state == S_SEND) ? byte_sel : 8'h00;

    // Shared IOP bus: release every driver while another channel is selected.
    assign memory_address  = active ? addr_int  : 'z;
    assign memory_data_out = active ? wdata_int : 'z;
    assign wr_enables      = active ? wen_int   : 'z;
    assign iop_cc          = active ? cc        : 'z;

endmodule
